// File: rtl/dim_controller.sv
// rtl/dim_controller.sv - 4-bit brightness level with manual buttons and breathe ramp,
// committed only on frame-boundary ticks.
module dim_controller #(
   parameter int         DEBOUNCE_CYCLES = 250000,
   parameter int         HOLD_CYCLES     = 12500000,
   parameter int         REPEAT_CYCLES   = 2500000,
   parameter int         BREATHE_FRAMES  = 4,
   parameter logic [3:0] RESET_LEVEL     = 4'd15
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       btnUp,
   input  logic       btnDown,
   input  logic       mode,
   input  logic       frameTick,
   output logic [3:0] dimCounter,
   output logic       atMax,
   output logic       atMin
);

   localparam int HMAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int DW   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW   = $clog2(HMAX + 1);
   localparam int FW   = (BREATHE_FRAMES > 1) ? $clog2(BREATHE_FRAMES) : 1;
   localparam logic [DW-1:0] DEB_LAST  = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_LAST = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] REP_LAST  = HW'(REPEAT_CYCLES - 1);
   localparam logic [FW-1:0] F_LAST    = FW'(BREATHE_FRAMES - 1);

   typedef enum logic [1:0] {MANUAL, BR_UP, BR_DOWN} state_t;

   // Index 0 is the up button, index 1 the down button.
   logic [1:0]    btn_meta, btn_sync, deb, deb_prev, in_repeat, press, step;
   logic [DW-1:0] deb_cnt  [2];
   logic [HW-1:0] hold_cnt [2];
   logic          mode_meta, mode_sync;
   logic          pend_up, pend_down;
   logic [FW-1:0] frame_cnt;
   logic [3:0]    level_next;
   logic          up_req, down_req, breathe_step;
   state_t        state;

   always_comb begin
      for (int i = 0; i < 2; i++) begin
         press[i] = deb[i] & ~deb_prev[i];
         step[i]  = press[i] | (deb[i] & ~press[i] &
                    (hold_cnt[i] == (in_repeat[i] ? REP_LAST : HOLD_LAST)));
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         btn_meta  <= '0;
         btn_sync  <= '0;
         mode_meta <= 1'b0;
         mode_sync <= 1'b0;
         deb       <= '0;
         deb_prev  <= '0;
         in_repeat <= '0;
         for (int i = 0; i < 2; i++) begin
            deb_cnt[i]  <= '0;
            hold_cnt[i] <= '0;
         end
      end else begin
         btn_meta  <= {btnDown, btnUp};
         btn_sync  <= btn_meta;
         mode_meta <= mode;
         mode_sync <= mode_meta;
         deb_prev  <= deb;
         for (int i = 0; i < 2; i++) begin
            if (btn_sync[i] != deb[i]) begin
               if (deb_cnt[i] == DEB_LAST) begin
                  deb[i]     <= ~deb[i];
                  deb_cnt[i] <= '0;
               end else begin
                  deb_cnt[i] <= deb_cnt[i] + 1'b1;
               end
            end else begin
               deb_cnt[i] <= '0;
            end
            // Hold counter restarts at every event; after the first repeat it uses the shorter period.
            if (!deb[i] || press[i]) begin
               hold_cnt[i]  <= '0;
               in_repeat[i] <= 1'b0;
            end else if (step[i]) begin
               hold_cnt[i]  <= '0;
               in_repeat[i] <= 1'b1;
            end else begin
               hold_cnt[i] <= hold_cnt[i] + 1'b1;
            end
         end
      end
   end

   assign up_req       = pend_up | step[0];
   assign down_req     = pend_down | step[1];
   assign breathe_step = frameTick && (frame_cnt == F_LAST);

   always_comb begin
      level_next = dimCounter;
      case (state)
         MANUAL: begin
            if (!mode_sync && frameTick) begin
               if (up_req && !down_req && dimCounter != 4'd15)
                  level_next = dimCounter + 4'd1;
               else if (down_req && !up_req && dimCounter != 4'd0)
                  level_next = dimCounter - 4'd1;
            end
         end
         BR_UP:   if (mode_sync && breathe_step && dimCounter != 4'd15) level_next = dimCounter + 4'd1;
         BR_DOWN: if (mode_sync && breathe_step && dimCounter != 4'd0)  level_next = dimCounter - 4'd1;
         default: level_next = dimCounter;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= MANUAL;
         frame_cnt  <= '0;
         pend_up    <= 1'b0;
         pend_down  <= 1'b0;
         dimCounter <= RESET_LEVEL;
         atMax      <= (RESET_LEVEL == 4'd15);
         atMin      <= (RESET_LEVEL == 4'd0);
      end else begin
         dimCounter <= level_next;
         atMax      <= (level_next == 4'd15);
         atMin      <= (level_next == 4'd0);
         case (state)
            MANUAL: begin
               if (mode_sync) begin
                  state     <= (dimCounter == 4'd15) ? BR_DOWN : BR_UP;
                  frame_cnt <= '0;
                  pend_up   <= 1'b0;
                  pend_down <= 1'b0;
               end else if (frameTick) begin
                  pend_up   <= 1'b0;
                  pend_down <= 1'b0;
               end else begin
                  if (step[0]) pend_up   <= 1'b1;
                  if (step[1]) pend_down <= 1'b1;
               end
            end
            BR_UP, BR_DOWN: begin
               if (!mode_sync) begin
                  state     <= MANUAL;
                  frame_cnt <= '0;
               end else if (frameTick) begin
                  frame_cnt <= breathe_step ? '0 : frame_cnt + 1'b1;
                  // Turn around in the same cycle the end value is reached.
                  if (state == BR_UP && level_next == 4'd15)  state <= BR_DOWN;
                  if (state == BR_DOWN && level_next == 4'd0) state <= BR_UP;
               end
            end
            default: state <= MANUAL;
         endcase
      end
   end

endmodule

// File: tb/tb_dim_controller.sv
// tb/tb_dim_controller.sv - scoreboard bench for dim_controller.
module tb_dim_controller;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       btnUp = 1'b0;
   logic       btnDown = 1'b0;
   logic       mode = 1'b0;
   logic       frameTick = 1'b0;
   logic [3:0] dimCounter;
   logic       atMax, atMin;

   logic [3:0] exp_q[$];
   int         tests = 0;
   int         fails = 0;
   bit         chk_next = 1'b0;
   bit         done = 1'b0;

   dim_controller #(
      .DEBOUNCE_CYCLES(4),
      .HOLD_CYCLES(20),
      .REPEAT_CYCLES(8),
      .BREATHE_FRAMES(2),
      .RESET_LEVEL(4'd15)
   ) dut (
      .clk(clk),
      .reset(reset),
      .btnUp(btnUp),
      .btnDown(btnDown),
      .mode(mode),
      .frameTick(frameTick),
      .dimCounter(dimCounter),
      .atMax(atMax),
      .atMin(atMin)
   );

   always #5 clk = ~clk;

   // Monitor: the cycle after a tick or reset pulse is where a new level appears.
   always @(negedge clk) begin
      logic [3:0] e;
      if (chk_next) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL unexpected_update: dim=%0d with no expected entry", dimCounter);
         end else begin
            e = exp_q.pop_front();
            if (dimCounter !== e || atMax !== (e == 4'd15) || atMin !== (e == 4'd0)) begin
               fails++;
               $display("FAIL level_check #%0d: got dim=%0d atMax=%0b atMin=%0b, expected dim=%0d atMax=%0b atMin=%0b",
                        tests, dimCounter, atMax, atMin, e, (e == 4'd15), (e == 4'd0));
            end
         end
      end
      chk_next = frameTick | reset;
      if (done) begin
         tests++;
         if (exp_q.size() != 0) begin
            fails++;
            $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
         end
         $display("[TB] %0d tests run, %0d failed", tests, fails);
         $finish;
      end
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish, expected completion");
      $fatal(1, "timeout");
   end

   task automatic step_cycles(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic tick(input logic [3:0] e);
      exp_q.push_back(e);
      frameTick = 1'b1;
      step_cycles(1);
      frameTick = 1'b0;
   endtask

   task automatic do_reset(input logic [3:0] e);
      exp_q.push_back(e);
      reset = 1'b1;
      step_cycles(1);
      reset = 1'b0;
   endtask

   task automatic press_btn(input bit up, input int n);
      if (up) btnUp = 1'b1;
      else    btnDown = 1'b1;
      step_cycles(n);
      btnUp = 1'b0;
      btnDown = 1'b0;
      step_cycles(10);
   endtask

   // Level seen after a tick in cycle t of the long hold: events at cycles 6, 26, 34, 42, ...
   function automatic logic [3:0] hold_level(input int t);
      int n;
      n = (t < 6) ? 0 : 1 + ((t >= 26) ? ((t - 26) / 8 + 1) : 0);
      return (n >= 15) ? 4'd0 : 4'(15 - n);
   endfunction

   initial begin
      logic [3:0] br_exp [10];
      br_exp = '{4'd13, 4'd14, 4'd14, 4'd15, 4'd15, 4'd14, 4'd14, 4'd13, 4'd13, 4'd12};
      step_cycles(2);

      // Reset value and saturation at the top.
      do_reset(4'd15);
      press_btn(1'b1, 10);
      tick(4'd15);

      // Debounce: short glitch ignored, long pulse steps down.
      press_btn(1'b0, 3);
      tick(4'd15);
      press_btn(1'b0, 10);
      tick(4'd14);

      // Collapse of several presses, and cancel of opposing presses.
      press_btn(1'b0, 10);
      press_btn(1'b0, 10);
      press_btn(1'b0, 10);
      tick(4'd13);
      press_btn(1'b1, 10);
      press_btn(1'b0, 10);
      tick(4'd13);
      tick(4'd13);

      // Auto-repeat from 15, ticks every 5 cycles, down to saturation at 0.
      do_reset(4'd15);
      for (int k = 0; k < 140; k++) begin
         if (k == 0) btnDown = 1'b1;
         if (k % 5 == 4) begin
            exp_q.push_back(hold_level(k));
            frameTick = 1'b1;
         end else begin
            frameTick = 1'b0;
         end
         step_cycles(1);
      end
      frameTick = 1'b0;
      btnDown = 1'b0;
      step_cycles(12);

      // Breathe ramp from 13, then freeze and manual control.
      do_reset(4'd15);
      press_btn(1'b0, 10);
      tick(4'd14);
      press_btn(1'b0, 10);
      tick(4'd13);
      mode = 1'b1;
      step_cycles(5);
      for (int k = 0; k < 10; k++) begin
         tick(br_exp[k]);
         step_cycles(9);
      end
      mode = 1'b0;
      step_cycles(5);
      tick(4'd12);
      tick(4'd12);
      press_btn(1'b1, 10);
      tick(4'd13);

      // Reset discards a pending step.
      press_btn(1'b0, 10);
      do_reset(4'd15);
      tick(4'd15);

      // Reset out of BR_DOWN with a half-counted frame.
      mode = 1'b1;
      step_cycles(5);
      tick(4'd15);
      do_reset(4'd15);
      tick(4'd15);
      step_cycles(5);
      tick(4'd15);
      tick(4'd14);
      mode = 1'b0;
      step_cycles(5);

      done = 1'b1;
   end

endmodule
